// File: rtl/bullet_scheduler.sv
// Bullet-slot allocator: turns held shoot levels into single requests and arbitrates both tanks onto a shared pool.
// Define BULLET_LIFETIME_EN to add per-slot lifetime counters that free a bullet after LIFETIME frames.
module bullet_scheduler #(
  parameter int unsigned NUM_SLOTS    = 4,
  parameter int unsigned MAX_PER_TANK = 2,
  parameter int unsigned COOLDOWN     = 8,
  parameter int unsigned LIFETIME     = 300
) (
  input  logic                         frame_clk,
  input  logic                         Reset,
  input  logic [1:0]                   game_end,
  input  logic                         shoot1,
  input  logic                         shoot2,
  input  logic [9:0]                   tank1_x,
  input  logic [9:0]                   tank1_y,
  input  logic [9:0]                   tank2_x,
  input  logic [9:0]                   tank2_y,
  input  logic [5:0]                   angle1,
  input  logic [5:0]                   angle2,
  input  logic [NUM_SLOTS-1:0]         slot_hit,
  output logic [NUM_SLOTS-1:0]         slot_active,
  output logic [NUM_SLOTS-1:0]         slot_owner,
  output logic                         spawn_valid,
  output logic [$clog2(NUM_SLOTS)-1:0] spawn_slot,
  output logic                         spawn_owner,
  output logic [9:0]                   spawn_x,
  output logic [9:0]                   spawn_y,
  output logic [5:0]                   spawn_angle,
  output logic [3:0]                   count1,
  output logic [3:0]                   count2
);

  localparam int unsigned SW      = $clog2(NUM_SLOTS);
  localparam logic [3:0]  MAX_C   = 4'(MAX_PER_TANK);
  localparam logic [7:0]  CD_INIT = 8'(COOLDOWN);

  logic                 prev1_q, prev2_q, pend1_q, pend2_q, rr_q;
  logic                 pend1_d, pend2_d, rr_d;
  logic [7:0]           cd1_q, cd2_q, cd1_d, cd2_d;
  logic [NUM_SLOTS-1:0] active_q, active_d, owner_q, owner_d, expire;
  logic                 spawn_valid_q, spawn_valid_d, spawn_owner_q, spawn_owner_d;
  logic [SW-1:0]        spawn_slot_q, spawn_slot_d, free_idx;
  logic [9:0]           spawn_x_q, spawn_x_d, spawn_y_q, spawn_y_d;
  logic [5:0]           spawn_angle_q, spawn_angle_d;
  logic [3:0]           cnt1, cnt2;
  logic                 round_end, any_free, elig1, elig2, grant1, grant2, grant_any;

  assign round_end = |game_end;
  assign any_free  = ~&active_q;

  always_comb begin
    free_idx = '0;
    for (int unsigned i = NUM_SLOTS; i > 0; i--) begin
      if (!active_q[i-1]) free_idx = SW'(i-1);
    end
  end

  always_comb begin
    cnt1 = '0;
    cnt2 = '0;
    for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
      if (active_q[i] && !owner_q[i]) cnt1 = cnt1 + 4'd1;
      if (active_q[i] &&  owner_q[i]) cnt2 = cnt2 + 4'd1;
    end
  end

  assign elig1     = pend1_q && (cd1_q == '0) && (cnt1 < MAX_C) && any_free;
  assign elig2     = pend2_q && (cd2_q == '0) && (cnt2 < MAX_C) && any_free;
  assign grant1    = !round_end && elig1 && (!elig2 || !rr_q);
  assign grant2    = !round_end && elig2 && (!elig1 ||  rr_q);
  assign grant_any = grant1 || grant2;

  // An eligible loser keeps its request; anything ineligible is dropped, never queued.
  always_comb begin
    pend1_d = 1'b0;
    pend2_d = 1'b0;
    cd1_d   = '0;
    cd2_d   = '0;
    rr_d    = 1'b0;
    if (!round_end) begin
      pend1_d = (shoot1 && !prev1_q) || (pend1_q && elig1 && !grant1);
      pend2_d = (shoot2 && !prev2_q) || (pend2_q && elig2 && !grant2);
      cd1_d   = grant1 ? CD_INIT : ((cd1_q == '0) ? '0 : cd1_q - 8'd1);
      cd2_d   = grant2 ? CD_INIT : ((cd2_q == '0) ? '0 : cd2_q - 8'd1);
      rr_d    = (elig1 && elig2) ? !rr_q : rr_q;
    end
  end

  always_comb begin
    active_d = active_q;
    owner_d  = owner_q;
    for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
      if (active_q[i] && (slot_hit[i] || expire[i])) active_d[i] = 1'b0;
      if (grant_any && (free_idx == SW'(i))) begin
        active_d[i] = 1'b1;
        owner_d[i]  = grant2;
      end
    end
    if (round_end) active_d = '0;
  end

  always_comb begin
    spawn_valid_d = grant_any;
    spawn_slot_d  = spawn_slot_q;
    spawn_owner_d = spawn_owner_q;
    spawn_x_d     = spawn_x_q;
    spawn_y_d     = spawn_y_q;
    spawn_angle_d = spawn_angle_q;
    if (grant_any) begin
      spawn_slot_d  = free_idx;
      spawn_owner_d = grant2;
      spawn_x_d     = grant2 ? tank2_x : tank1_x;
      spawn_y_d     = grant2 ? tank2_y : tank1_y;
      spawn_angle_d = grant2 ? angle2  : angle1;
    end
  end

`ifdef BULLET_LIFETIME_EN
  localparam logic [9:0] LIFE_INIT = 10'(LIFETIME);
  logic [9:0] life_q [NUM_SLOTS];
  logic [9:0] life_d [NUM_SLOTS];

  always_comb begin
    for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
      expire[i] = active_q[i] && (life_q[i] == 10'd1);
      life_d[i] = life_q[i];
      if (grant_any && (free_idx == SW'(i))) life_d[i] = LIFE_INIT;
      else if (active_q[i] && (life_q[i] != '0)) life_d[i] = life_q[i] - 10'd1;
      if (round_end) life_d[i] = '0;
    end
  end

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      for (int unsigned i = 0; i < NUM_SLOTS; i++) life_q[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_SLOTS; i++) life_q[i] <= life_d[i];
    end
  end
`else
  assign expire = '0;
`endif

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      prev1_q       <= 1'b0;
      prev2_q       <= 1'b0;
      pend1_q       <= 1'b0;
      pend2_q       <= 1'b0;
      rr_q          <= 1'b0;
      cd1_q         <= '0;
      cd2_q         <= '0;
      active_q      <= '0;
      owner_q       <= '0;
      spawn_valid_q <= 1'b0;
      spawn_slot_q  <= '0;
      spawn_owner_q <= 1'b0;
      spawn_x_q     <= '0;
      spawn_y_q     <= '0;
      spawn_angle_q <= '0;
    end else begin
      prev1_q       <= shoot1;
      prev2_q       <= shoot2;
      pend1_q       <= pend1_d;
      pend2_q       <= pend2_d;
      rr_q          <= rr_d;
      cd1_q         <= cd1_d;
      cd2_q         <= cd2_d;
      active_q      <= active_d;
      owner_q       <= owner_d;
      spawn_valid_q <= spawn_valid_d;
      spawn_slot_q  <= spawn_slot_d;
      spawn_owner_q <= spawn_owner_d;
      spawn_x_q     <= spawn_x_d;
      spawn_y_q     <= spawn_y_d;
      spawn_angle_q <= spawn_angle_d;
    end
  end

  assign slot_active = active_q;
  assign slot_owner  = owner_q;
  assign spawn_valid = spawn_valid_q;
  assign spawn_slot  = spawn_slot_q;
  assign spawn_owner = spawn_owner_q;
  assign spawn_x     = spawn_x_q;
  assign spawn_y     = spawn_y_q;
  assign spawn_angle = spawn_angle_q;
  assign count1      = cnt1;
  assign count2      = cnt2;

endmodule

// File: tb/tb_bullet_scheduler.sv
// Directed bench for bullet_scheduler; a second instance with a higher per-tank limit isolates pool-full drops.
module tb_bullet_scheduler;
  localparam int LIFE = 300;

  logic       frame_clk = 1'b0;
  logic       Reset = 1'b0;
  logic [1:0] game_end = 2'b00;
  logic       shoot1 = 1'b0, shoot2 = 1'b0;
  logic [9:0] tank1_x = 10'd0, tank1_y = 10'd0, tank2_x = 10'd0, tank2_y = 10'd0;
  logic [5:0] angle1 = 6'd0, angle2 = 6'd0;
  logic [3:0] slot_hit = 4'b0000;

  logic [3:0] slot_active, slot_owner, count1, count2;
  logic       spawn_valid, spawn_owner;
  logic [1:0] spawn_slot;
  logic [9:0] spawn_x, spawn_y;
  logic [5:0] spawn_angle;

  logic [3:0] d2_slot_active, d2_slot_owner, d2_count1, d2_count2;
  logic       d2_spawn_valid, d2_spawn_owner;
  logic [1:0] d2_spawn_slot;
  logic [9:0] d2_spawn_x, d2_spawn_y;
  logic [5:0] d2_spawn_angle;

  int errors = 0;
  int checks = 0;

  always #5 frame_clk = ~frame_clk;

  bullet_scheduler #(.NUM_SLOTS(4), .MAX_PER_TANK(2), .COOLDOWN(8), .LIFETIME(LIFE)) dut (
    .frame_clk(frame_clk), .Reset(Reset), .game_end(game_end),
    .shoot1(shoot1), .shoot2(shoot2),
    .tank1_x(tank1_x), .tank1_y(tank1_y), .tank2_x(tank2_x), .tank2_y(tank2_y),
    .angle1(angle1), .angle2(angle2), .slot_hit(slot_hit),
    .slot_active(slot_active), .slot_owner(slot_owner),
    .spawn_valid(spawn_valid), .spawn_slot(spawn_slot), .spawn_owner(spawn_owner),
    .spawn_x(spawn_x), .spawn_y(spawn_y), .spawn_angle(spawn_angle),
    .count1(count1), .count2(count2)
  );

  bullet_scheduler #(.NUM_SLOTS(4), .MAX_PER_TANK(4), .COOLDOWN(8), .LIFETIME(LIFE)) dut2 (
    .frame_clk(frame_clk), .Reset(Reset), .game_end(game_end),
    .shoot1(shoot1), .shoot2(shoot2),
    .tank1_x(tank1_x), .tank1_y(tank1_y), .tank2_x(tank2_x), .tank2_y(tank2_y),
    .angle1(angle1), .angle2(angle2), .slot_hit(slot_hit),
    .slot_active(d2_slot_active), .slot_owner(d2_slot_owner),
    .spawn_valid(d2_spawn_valid), .spawn_slot(d2_spawn_slot), .spawn_owner(d2_spawn_owner),
    .spawn_x(d2_spawn_x), .spawn_y(d2_spawn_y), .spawn_angle(d2_spawn_angle),
    .count1(d2_count1), .count2(d2_count2)
  );

  task tick;
    @(posedge frame_clk);
    #1;
  endtask

  // Advances n cycles and returns how many spawn strobes the selected instance issued.
  task run_count(input int n, input bit use_d2, output int s);
    s = 0;
    for (int i = 0; i < n; i++) begin
      tick();
      if (use_d2 ? d2_spawn_valid : spawn_valid) s++;
    end
  endtask

  task do_reset;
    @(negedge frame_clk);
    Reset = 1'b1;
    shoot1 = 1'b0; shoot2 = 1'b0; game_end = 2'b00; slot_hit = 4'b0000;
    @(negedge frame_clk);
    Reset = 1'b0;
    tick();
  endtask

  task test_reset;
    #1 Reset = 1'b1;
    #2;
    checks++;
    if ({slot_active, slot_owner, spawn_valid, spawn_slot, spawn_owner, spawn_x, spawn_y,
         spawn_angle, count1, count2} !== 46'd0) begin
      errors++;
      $display("FAIL reset_outputs: got act=%b own=%b sv=%b slot=%0d so=%b x=%0d y=%0d a=%0d c1=%0d c2=%0d, need all 0",
               slot_active, slot_owner, spawn_valid, spawn_slot, spawn_owner, spawn_x, spawn_y,
               spawn_angle, count1, count2);
    end
    do_reset();
  endtask

  task test_single_shot;
    int s;
    do_reset();
    tank1_x = 10'd100; tank1_y = 10'd200; angle1 = 6'd7;
    shoot1 = 1'b1;
    tick();
    checks++;
    if (spawn_valid !== 1'b0) begin errors++; $display("FAIL single_early: spawn_valid=%b need 0", spawn_valid); end
    tick();
    checks++;
    if ({spawn_valid, spawn_slot, spawn_owner, spawn_x, spawn_y, spawn_angle} !== {1'b1, 2'd0, 1'b0, 10'd100, 10'd200, 6'd7}) begin
      errors++;
      $display("FAIL single_spawn: sv=%b slot=%0d own=%b x=%0d y=%0d a=%0d need 1,0,0,100,200,7",
               spawn_valid, spawn_slot, spawn_owner, spawn_x, spawn_y, spawn_angle);
    end
    checks++;
    if ({slot_active, count1, count2} !== {4'b0001, 4'd1, 4'd0}) begin
      errors++; $display("FAIL single_state: act=%b c1=%0d c2=%0d need 0001,1,0", slot_active, count1, count2);
    end
    tank1_x = 10'd555;
    tick();
    checks++;
    if ({spawn_valid, spawn_x} !== {1'b0, 10'd100}) begin
      errors++; $display("FAIL single_hold: sv=%b x=%0d need 0,100", spawn_valid, spawn_x);
    end
    run_count(20, 1'b0, s);
    checks++;
    if (s !== 0) begin errors++; $display("FAIL single_held_key: spawns=%0d need 0", s); end
    shoot1 = 1'b0;
  endtask

  task test_simultaneous;
    do_reset();
    tank1_x = 10'd100; tank1_y = 10'd200; angle1 = 6'd7;
    tank2_x = 10'd300; tank2_y = 10'd400; angle2 = 6'd20;
    shoot1 = 1'b1; shoot2 = 1'b1;
    tick();
    tick();
    checks++;
    if ({spawn_valid, spawn_slot, spawn_owner, spawn_x} !== {1'b1, 2'd0, 1'b0, 10'd100}) begin
      errors++; $display("FAIL simul_first: sv=%b slot=%0d own=%b x=%0d need 1,0,0,100", spawn_valid, spawn_slot, spawn_owner, spawn_x);
    end
    tick();
    checks++;
    if ({spawn_valid, spawn_slot, spawn_owner, spawn_x, spawn_y, spawn_angle} !== {1'b1, 2'd1, 1'b1, 10'd300, 10'd400, 6'd20}) begin
      errors++; $display("FAIL simul_second: sv=%b slot=%0d own=%b x=%0d y=%0d a=%0d need 1,1,1,300,400,20",
                         spawn_valid, spawn_slot, spawn_owner, spawn_x, spawn_y, spawn_angle);
    end
    shoot1 = 1'b0; shoot2 = 1'b0;
    repeat (10) tick();
    shoot1 = 1'b1; shoot2 = 1'b1;
    tick();
    tick();
    checks++;
    if ({spawn_valid, spawn_slot, spawn_owner} !== {1'b1, 2'd2, 1'b1}) begin
      errors++; $display("FAIL simul_rr_tank2: sv=%b slot=%0d own=%b need 1,2,1", spawn_valid, spawn_slot, spawn_owner);
    end
    tick();
    checks++;
    if ({spawn_valid, spawn_slot, spawn_owner} !== {1'b1, 2'd3, 1'b0}) begin
      errors++; $display("FAIL simul_rr_tank1: sv=%b slot=%0d own=%b need 1,3,0", spawn_valid, spawn_slot, spawn_owner);
    end
    checks++;
    if ({slot_active, slot_owner, count1, count2} !== {4'b1111, 4'b0110, 4'd2, 4'd2}) begin
      errors++; $display("FAIL simul_state: act=%b own=%b c1=%0d c2=%0d need 1111,0110,2,2", slot_active, slot_owner, count1, count2);
    end
    shoot1 = 1'b0; shoot2 = 1'b0;
  endtask

  task test_per_tank_limit;
    int s, total;
    do_reset();
    total = 0;
    for (int n = 0; n < 3; n++) begin
      shoot1 = 1'b1;
      tick();
      shoot1 = 1'b0;
      run_count(11, 1'b0, s);
      total += s;
    end
    checks++;
    if ({total[3:0], slot_active, count1} !== {4'd2, 4'b0011, 4'd2}) begin
      errors++; $display("FAIL limit_drop: spawns=%0d act=%b c1=%0d need 2,0011,2", total, slot_active, count1);
    end
    slot_hit = 4'b0001;
    tick();
    slot_hit = 4'b0000;
    checks++;
    if ({slot_active, count1} !== {4'b0010, 4'd1}) begin
      errors++; $display("FAIL limit_hit_free: act=%b c1=%0d need 0010,1", slot_active, count1);
    end
    shoot1 = 1'b1;
    tick();
    shoot1 = 1'b0;
    tick();
    checks++;
    if ({spawn_valid, spawn_slot, slot_active} !== {1'b1, 2'd0, 4'b0011}) begin
      errors++; $display("FAIL limit_refill: sv=%b slot=%0d act=%b need 1,0,0011", spawn_valid, spawn_slot, slot_active);
    end
  endtask

  task test_cooldown;
    int s;
    do_reset();
    shoot1 = 1'b1;
    tick();
    shoot1 = 1'b0;
    tick();
    checks++;
    if ({spawn_valid, spawn_slot} !== {1'b1, 2'd0}) begin
      errors++; $display("FAIL cd_first: sv=%b slot=%0d need 1,0", spawn_valid, spawn_slot);
    end
    tick();
    tick();
    shoot1 = 1'b1;
    tick();
    shoot1 = 1'b0;
    run_count(6, 1'b0, s);
    checks++;
    if (s !== 0) begin errors++; $display("FAIL cd_early_drop: spawns=%0d need 0", s); end
    shoot1 = 1'b1;
    tick();
    shoot1 = 1'b0;
    tick();
    checks++;
    if ({spawn_valid, spawn_slot, count1} !== {1'b1, 2'd1, 4'd2}) begin
      errors++; $display("FAIL cd_late_grant: sv=%b slot=%0d c1=%0d need 1,1,2", spawn_valid, spawn_slot, count1);
    end
  endtask

  task test_pool_full;
    int s;
    do_reset();
    for (int n = 0; n < 3; n++) begin
      shoot1 = 1'b1;
      tick();
      shoot1 = 1'b0;
      repeat (11) tick();
    end
    shoot2 = 1'b1;
    tick();
    shoot2 = 1'b0;
    repeat (11) tick();
    checks++;
    if ({d2_slot_active, d2_slot_owner, d2_count1, d2_count2} !== {4'b1111, 4'b1000, 4'd3, 4'd1}) begin
      errors++; $display("FAIL pool_fill: act=%b own=%b c1=%0d c2=%0d need 1111,1000,3,1", d2_slot_active, d2_slot_owner, d2_count1, d2_count2);
    end
    shoot2 = 1'b1;
    tick();
    shoot2 = 1'b0;
    run_count(3, 1'b1, s);
    checks++;
    if (s !== 0) begin errors++; $display("FAIL pool_full_drop: spawns=%0d need 0", s); end
    shoot2 = 1'b1;
    tick();
    shoot2 = 1'b0;
    slot_hit = 4'b0100;
    tick();
    slot_hit = 4'b0000;
    checks++;
    if ({d2_spawn_valid, d2_slot_active} !== {1'b0, 4'b1011}) begin
      errors++; $display("FAIL pool_same_cycle_free: sv=%b act=%b need 0,1011", d2_spawn_valid, d2_slot_active);
    end
    tick();
    checks++;
    if (d2_spawn_valid !== 1'b0) begin errors++; $display("FAIL pool_not_queued: sv=%b need 0", d2_spawn_valid); end
    shoot2 = 1'b1;
    tick();
    shoot2 = 1'b0;
    tick();
    checks++;
    if ({d2_spawn_valid, d2_spawn_slot, d2_spawn_owner, d2_slot_active, d2_count2} !== {1'b1, 2'd2, 1'b1, 4'b1111, 4'd2}) begin
      errors++; $display("FAIL pool_realloc: sv=%b slot=%0d own=%b act=%b c2=%0d need 1,2,1,1111,2",
                         d2_spawn_valid, d2_spawn_slot, d2_spawn_owner, d2_slot_active, d2_count2);
    end
    #2 Reset = 1'b1;
    #1;
    checks++;
    if ({d2_slot_active, d2_count1, d2_count2, d2_spawn_valid} !== 13'd0) begin
      errors++; $display("FAIL async_reset: act=%b c1=%0d c2=%0d sv=%b need 0", d2_slot_active, d2_count1, d2_count2, d2_spawn_valid);
    end
    @(negedge frame_clk);
    Reset = 1'b0;
    tick();
  endtask

  task test_round_end_lifetime;
    int s;
    logic exp_live;
    do_reset();
    shoot1 = 1'b1; shoot2 = 1'b1;
    repeat (3) tick();
    shoot1 = 1'b0; shoot2 = 1'b0;
    repeat (10) tick();
    shoot1 = 1'b1;
    tick();
    shoot1 = 1'b0;
    tick();
    checks++;
    if (slot_active !== 4'b0111) begin errors++; $display("FAIL round_setup: act=%b need 0111", slot_active); end
    game_end = 2'b01;
    shoot2 = 1'b1;
    tick();
    checks++;
    if ({slot_active, count1, count2, spawn_valid} !== 13'd0) begin
      errors++; $display("FAIL round_clear: act=%b c1=%0d c2=%0d sv=%b need 0", slot_active, count1, count2, spawn_valid);
    end
    tick();
    game_end = 2'b00;
    run_count(4, 1'b0, s);
    checks++;
    if (s !== 0) begin errors++; $display("FAIL round_held_key: spawns=%0d need 0", s); end
    shoot2 = 1'b0;
    tank1_x = 10'd5; tank1_y = 10'd6; angle1 = 6'd44;
    tick();
    shoot1 = 1'b1;
    tick();
    shoot1 = 1'b0;
    tick();
    checks++;
    if ({spawn_valid, spawn_slot, spawn_x, spawn_y, spawn_angle} !== {1'b1, 2'd0, 10'd5, 10'd6, 6'd44}) begin
      errors++; $display("FAIL post_round_spawn: sv=%b slot=%0d x=%0d y=%0d a=%0d need 1,0,5,6,44",
                         spawn_valid, spawn_slot, spawn_x, spawn_y, spawn_angle);
    end
    repeat (LIFE - 1) tick();
    checks++;
    if (slot_active[0] !== 1'b1) begin errors++; $display("FAIL life_before: act0=%b need 1", slot_active[0]); end
    tick();
`ifdef BULLET_LIFETIME_EN
    exp_live = 1'b0;
`else
    exp_live = 1'b1;
`endif
    checks++;
    if (slot_active[0] !== exp_live) begin errors++; $display("FAIL life_expiry: act0=%b need %b", slot_active[0], exp_live); end
  endtask

  initial begin
    test_reset();
    test_single_shot();
    test_simultaneous();
    test_per_tank_limit();
    test_cooldown();
    test_pool_full();
    test_round_end_lifetime();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bullet_scheduler.md
# bullet_scheduler

Shared bullet-slot allocator for the two-tank game. It converts each tank's held `ShootBullet` level into single fire requests and arbitrates the two tanks onto a pool of bullet slots. For every granted shot it captures the shooter's position and angle and issues a one-cycle spawn command to the bullet datapath. It also frees slots on hit or expiry, and clears the pool at round end.

## Interface
Parameters:
- `NUM_SLOTS`, 4: bullet slots in the pool; a power of two, 2..8.
- `MAX_PER_TANK`, 2: maximum live bullets per tank; 1..`NUM_SLOTS`.
- `COOLDOWN`, 8: frames after a grant before the same tank may fire again; range 0..255.
- `LIFETIME`, 300: frames a bullet lives; range 1..1023.

Ports:
- `frame_clk` in 1: the only clock; one cycle = one frame.
- `Reset` in 1: asynchronous, active-high.
- `game_end` in 2: nonzero = round over; synchronous pool clear.
- `shoot1`, `shoot2` in 1: `ShootBullet` level from tank 1 / tank 2.
- `tank1_x`, `tank1_y`, `tank2_x`, `tank2_y` in 10: tank positions in pixels.
- `angle1`, `angle2` in 6: tank angle index, 0..44.
- `slot_hit` in `NUM_SLOTS`: per-slot "bullet hit something"; frees the slot.
- `slot_active` out `NUM_SLOTS`: slot holds a live bullet.
- `slot_owner` out `NUM_SLOTS`: per-slot owner; 0 = tank 1, 1 = tank 2.
- `spawn_valid` out 1: one-cycle spawn strobe.
- `spawn_slot` out clog2(`NUM_SLOTS`): slot being loaded.
- `spawn_owner` out 1: owner of the spawned bullet.
- `spawn_x`, `spawn_y` out 10: captured shooter position.
- `spawn_angle` out 6: captured shooter angle.
- `count1`, `count2` out 4: live bullets per tank.

## Operation
- **Edge detect.** `shootN` is registered as `prevN`. A rise (`shootN & ~prevN`) sets `pendN`. A held key fires once only.
- **Eligibility.** Tank N is eligible when all of these hold: `pendN`, `cdN == 0`, `countN < MAX_PER_TANK`, and at least one inactive slot.
- **Arbitration.**
  - If exactly one tank is eligible, it is granted.
  - If both are eligible, the tank named by `rr` is granted. `rr` then points at the other tank. The loser keeps `pend` and is re-evaluated next cycle.
  - At most one grant per cycle.
- **Drop rule.** A pending request that is not eligible for cooldown, count or pool-full reasons is cleared. Shots are never queued.
- **Allocation.**
  - The granted slot is the lowest-index slot inactive at the start of the cycle.
  - At the edge: slot goes active, owner is recorded, `spawn_*` outputs are loaded, `cdN` ← `COOLDOWN`, `pendN` ← 0.
- **Cooldown.** `cdN` decrements by 1 per cycle and saturates at 0.
- **Free.**
  - `slot_hit[i]` on an active slot clears it at the next edge.
  - A hit on an inactive slot is ignored.
  - A slot freed in cycle k becomes allocatable only in cycle k+1.
- **Counts.** `count1` and `count2` are the popcount of active slots per owner, derived from registered state and always consistent with `slot_active`.
- **Round clear.** While `game_end != 0`, all of the following are held at 0: `slot_active`, `pend1`, `pend2`, `cd1`, `cd2` and `spawn_valid`, and `rr` is held at tank 1. `prevN` keeps tracking `shootN`, so a key held across the round boundary does not fire.

## Timing
- **Reset values.** All outputs are 0: `slot_active`, `slot_owner`, `spawn_valid`, `spawn_slot`, `spawn_owner`, `spawn_x`, `spawn_y`, `spawn_angle`, `count1`, `count2`. Internal `prev`, `pend`, `cd` and lifetime counters are 0; `rr` points at tank 1.
- **Shot latency.** For a rise sampled at edge k (pend set at k), evaluated and granted at edge k+1: `spawn_valid` is high for the single cycle after edge k+1. From that edge, `slot_active` and the `count` outputs reflect the new bullet.
- **Captured values.** `spawn_x`, `spawn_y` and `spawn_angle` are the values present at the granting edge. They hold until the next grant; `spawn_valid` returns to 0.
- **Losing arbitration.** The loser is granted one cycle later, if it is still eligible.
- **Reset mid-round.** `Reset` clears all state immediately, independent of `frame_clk`.

## Configuration
- **`BULLET_LIFETIME_EN` defined.**
  - Each slot has a 10-bit counter, loaded with `LIFETIME` at grant and decremented each cycle while active.
  - When it reaches 1, the slot frees at the next edge.
  - A hit and an expiry in the same cycle free the slot once.
- **`BULLET_LIFETIME_EN` undefined.** There are no counters; slots free only on `slot_hit` or `game_end`.

## Test plan
- **Single shot.** Reset, then raise `shoot1` at edge k with tank1=(100,200), angle 7 → `spawn_valid` for one cycle after k+1, slot 0, owner 0, (100,200,7); `count1` = 1. Hold `shoot1` for 20 cycles → no further spawn.
- **Simultaneous shots.** Both tanks rise in the same cycle, `rr` = tank 1 → tank 1 gets slot 0 at k+1, tank 2 gets slot 1 at k+2. Repeat after the `COOLDOWN` frames have elapsed → tank 2 is granted first.
- **Per-tank limit.** Tank 1 fires 3 times, spaced > `COOLDOWN` → only 2 spawns; the 3rd is dropped; `count1` stays 2. Pulse `slot_hit` on one of them, then fire → spawn into the freed (lowest) slot.
- **Cooldown.** A second rise 3 cycles after a grant, with `COOLDOWN` = 8 → dropped, no spawn. A rise 10 cycles after the grant → granted.
- **Pool full.** 4 slots active → a rise is dropped. `slot_hit[2]` at cycle k and a rise in the same cycle → dropped. A rise at k+1 → slot 2 allocated.
- **Round end and lifetime.** Set `game_end` = 1 with 3 bullets live → all `slot_active` = 0 next cycle. With `BULLET_LIFETIME_EN` and `LIFETIME` = 5 → a bullet frees exactly 5 cycles after its spawn edge.
